// File: rtl/avmm_fill_check_master.sv
// Avalon-MM memory self-test master: fills a word range with seed+i, reads it back,
// and reports the mismatch count and the first failing address.
module avmm_fill_check_master #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    word_count,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    error_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   av_address,
    output logic [DATA_W/8-1:0] av_byteenable,
    output logic                av_chipselect,
    output logic                av_write,
    output logic                av_read,
    output logic [DATA_W-1:0]   av_writedata,
    input  logic [DATA_W-1:0]   av_readdata,
    input  logic                av_waitrequest
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;
    localparam int         LAST     = READ_LATENCY - 1;

    logic [2:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] seed_q;
    logic [CNT_W-1:0]  idx;

    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] beat_data;
    logic              accept;
    logic              last_beat;
    logic              pipe_busy;
    logic              miss;

    // Read-tracking pipeline: stage 0 is loaded on read acceptance, stage LAST lines up with readdata.
    logic              vld_p [READ_LATENCY];
    logic [DATA_W-1:0] exp_p [READ_LATENCY];
    logic [ADDR_W-1:0] adr_p [READ_LATENCY];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign beat_addr     = base_q + ADDR_W'(idx);
    assign beat_data     = seed_q + DATA_W'(idx);
    assign av_chipselect = (state == S_WRITE) || (state == S_READ);
    assign av_write      = (state == S_WRITE);
    assign av_read       = (state == S_READ);
    assign av_address    = av_chipselect ? beat_addr : '0;
    assign av_writedata  = av_write ? beat_data : '0;
    assign av_byteenable = {(DATA_W/8){av_chipselect}};
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_FINISH);
    assign accept        = av_chipselect && !av_waitrequest;
    assign last_beat     = (idx == count_q - CNT_W'(1));
    assign miss          = vld_p[LAST] && (av_readdata != exp_p[LAST]);

    always_comb begin
        pipe_busy = 1'b0;
        for (int k = 0; k < READ_LATENCY; k++) begin
            pipe_busy = pipe_busy | vld_p[k];
        end
    end

    // Stage boundary: expected data and address follow their valid bit down the pipeline.
    always_ff @(posedge clk) begin
        exp_p[0] <= beat_data;
        adr_p[0] <= beat_addr;
        for (int k = 1; k < READ_LATENCY; k++) begin
            exp_p[k] <= exp_p[k-1];
            adr_p[k] <= adr_p[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            idx            <= '0;
            error_count    <= '0;
            first_err_addr <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                vld_p[k] <= 1'b0;
            end
        end else begin
            vld_p[0] <= (state == S_READ) && accept;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_p[k] <= vld_p[k-1];
            end

            if (miss) begin
                error_count <= sat_inc(error_count);
                if (error_count == '0) begin
                    first_err_addr <= adr_p[LAST];
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q         <= base_addr;
                        count_q        <= word_count;
                        seed_q         <= seed;
                        idx            <= '0;
                        error_count    <= '0;
                        first_err_addr <= '0;
                        state          <= (word_count == '0) ? S_FINISH : S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (accept) begin
                        if (last_beat) begin
                            idx   <= '0;
                            state <= S_READ;
                        end else begin
                            idx <= idx + CNT_W'(1);
                        end
                    end
                end
                S_READ: begin
                    if (accept) begin
                        if (last_beat) begin
                            state <= S_DRAIN;
                        end else begin
                            idx <= idx + CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!pipe_busy) begin
                        state <= S_FINISH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
